// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the datapath controller: FSM states, instruction classes,
// opcode/ALU constants, writeback selects and immediate sign-extension helpers.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_MOV_IMM = 3'd0,
        CLS_MOV_REG = 3'd1,
        CLS_ADD     = 3'd2,
        CLS_CMP     = 3'd3,
        CLS_AND     = 3'd4,
        CLS_MVN     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } iclass_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [3:0] VSEL_NONE  = 4'b0000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0001;
    localparam logic [3:0] VSEL_DPOUT = 4'b0010;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction-register decoder: splits the IR into fields,
// classifies the instruction and produces both sign-extended immediates.
module ctrl_decode
    import dp_ctrl_pkg::*;
(
    input  logic [15:0] ir_i,
    output iclass_e     cls_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [1:0]  sh_o,
    output logic [1:0]  op_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o,
    output logic        illegal_o
);

    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign op_o     = ir_i[12:11];
    assign sximm8_o = sext8(ir_i[7:0]);
    assign sximm5_o = sext5(ir_i[4:0]);
    assign illegal_o = (cls_o == CLS_ILLEGAL);

    // Instruction classification from opcode and op fields
    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (ir_i[15:13])
            OPC_MOV: begin
                if (ir_i[12:11] == OP_MOV_IMM) begin
                    cls_o = CLS_MOV_IMM;
                end else if (ir_i[12:11] == OP_MOV_REG) begin
                    cls_o = CLS_MOV_REG;
                end else begin
                    cls_o = CLS_ILLEGAL;
                end
            end
            OPC_ALU: begin
                case (ir_i[12:11])
                    ALU_ADD:  cls_o = CLS_ADD;
                    ALU_SUB:  cls_o = CLS_CMP;
                    ALU_AND:  cls_o = CLS_AND;
                    ALU_NOTB: cls_o = CLS_MVN;
                    default:  cls_o = CLS_ILLEGAL;
                endcase
            end
            default: cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Instruction register and control FSM that sequences the register-file /
// shifter / ALU datapath one instruction at a time with Moore strobes.
module datapath_controller
    import dp_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [3:0]  vsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        err_q, err_d;

    iclass_e     cls_s;
    logic [2:0]  rn_s, rd_s, rm_s;
    logic [1:0]  sh_s, op_s;
    logic        illegal_s;

    ctrl_decode u_decode (
        .ir_i      (ir_q),
        .cls_o     (cls_s),
        .rn_o      (rn_s),
        .rd_o      (rd_s),
        .rm_o      (rm_s),
        .sh_o      (sh_s),
        .op_o      (op_s),
        .sximm8_o  (sximm8),
        .sximm5_o  (sximm5),
        .illegal_o (illegal_s)
    );

    // State, instruction and error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
            ir_q    <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; IR and err only change while idle or decoding
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        err_d   = err_q;
        case (state_q)
            ST_WAIT: begin
                if (load) begin
                    ir_d = in;
                end else begin
                    ir_d = ir_q;
                end
                if (s) begin
                    state_d = ST_DECODE;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DECODE: begin
                if (illegal_s) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    case (cls_s)
                        CLS_MOV_IMM: state_d = ST_WRITE_IMM;
                        CLS_MOV_REG: state_d = ST_GET_B;
                        CLS_MVN:     state_d = ST_GET_B;
                        default:     state_d = ST_GET_A;
                    endcase
                end
            end
            ST_WRITE_IMM: state_d = ST_WAIT;
            ST_GET_A:     state_d = ST_GET_B;
            ST_GET_B:     state_d = ST_EXEC;
            ST_EXEC: begin
                if (cls_s == CLS_CMP) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: state_d = ST_WAIT;
            default:      state_d = ST_WAIT;
        endcase
    end

    // Moore output decode from the current state and IR fields
    always_comb begin
        w        = 1'b0;
        err      = err_q;
        vsel     = VSEL_NONE;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state_q)
            ST_WAIT: w = 1'b1;
            ST_WRITE_IMM: begin
                writenum = rn_s;
                vsel     = VSEL_IMM8;
                write    = 1'b1;
            end
            ST_GET_A: begin
                readnum = rn_s;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm_s;
                loadb   = 1'b1;
            end
            ST_EXEC: begin
                shift = sh_s;
                if (cls_s == CLS_MOV_REG) begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                    loadc = 1'b1;
                end else if (cls_s == CLS_CMP) begin
                    ALUop = op_s;
                    loads = 1'b1;
                end else begin
                    ALUop = op_s;
                    loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                writenum = rd_s;
                vsel     = VSEL_DPOUT;
                write    = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
Control FSM and instruction register that sequences the 16-bit register-file/shifter/ALU datapath, one instruction at a time. It latches a 16-bit instruction and decodes it into register selects, sign-extended immediates and operation codes. It then drives the datapath's load, select and write strobes cycle by cycle. A host or testbench hands over each instruction with load/s and waits for w to return high.

Parameters:
None. ISA widths are fixed: 16-bit instruction, 8 registers.

Ports:
clk        in   1   rising-edge clock
reset_n    in   1   asynchronous, active-low reset
s          in   1   start; sampled only in WAIT
load       in   1   instruction register load enable; honoured only in WAIT
in         in   16  instruction word
w          out  1   high only in WAIT (idle / ready)
err        out  1   sticky illegal-instruction flag
vsel       out  4   one-hot writeback select: 0001 sximm8, 0010 datapath_out, 0100 PC, 1000 mdata
readnum    out  3   register-file read index
writenum   out  3   register-file write index
write      out  1   register-file write strobe
loada      out  1   A register load
loadb      out  1   B register load
asel       out  1   1 = A operand forced to zero
bsel       out  1   1 = B operand is sximm5
shift      out  2   shifter control
ALUop      out  2   00 ADD, 01 SUB/CMP, 10 AND, 11 NOT B
loadc      out  1   C register load
loads      out  1   status (Z/V/N) register load
sximm8     out  16  sign-extended IR[7:0]
sximm5     out  16  sign-extended IR[4:0]

Behaviour:
- Instruction register fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Legal instructions:
  - MOV Rn,#im8: opcode 110, op 10.
  - MOV Rd,Rm,sh: opcode 110, op 00.
  - ADD: opcode 101, op 00.
  - CMP: opcode 101, op 01.
  - AND: opcode 101, op 10.
  - MVN: opcode 101, op 11.
  - All other encodings are illegal.
- Instruction register loading: IR <= in on the clock edge when load=1 and state=WAIT. Otherwise IR holds.
- Outputs are Moore outputs, decoded from state and IR. sximm8 and sximm5 are always driven from IR.
- Outside the states listed below, every strobe and select is 0, vsel=0000, and readnum/writenum/shift/ALUop are 0.
- Reset (async, reset_n=0):
  - state=WAIT, IR=0, err=0.
  - Hence w=1, all strobes 0, sximm8=0, sximm5=0.
  - Reset asserted mid-instruction aborts it immediately; no write occurs after reset assertion.
- FSM states and transitions:
  - WAIT: w=1. If s=1, go to DECODE. If load=1 and s=1 on the same edge, the newly loaded IR is the one decoded.
  - DECODE (no strobes):
    - Illegal encoding: set err, go to WAIT.
    - MOV imm: go to WRITE_IMM.
    - MOV reg or MVN: go to GET_B.
    - ADD, CMP, AND: go to GET_A.
  - WRITE_IMM: writenum=Rn, vsel=0001, write=1. Go to WAIT.
  - GET_A: readnum=Rn, loada=1. Go to GET_B.
  - GET_B: readnum=Rm, loadb=1. Go to EXEC.
  - EXEC: shift=sh, bsel=0, ALUop=op.
    - MOV reg: asel=1, ALUop=00, loadc=1.
    - CMP: asel=0, loads=1, loadc=0. Go to WAIT.
    - All others: asel=0, loadc=1. Go to WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=0010, write=1. Go to WAIT.
- Latency, counted from the s-sampling edge to w=1:
  - MOV imm: 2 cycles.
  - CMP: 4 cycles.
  - ADD, AND: 5 cycles.
  - MOV reg, MVN: 4 cycles.
  - Illegal: 1 cycle.
- s and load while not in WAIT are ignored; there is no queuing.
- err is cleared on the edge where s is accepted in WAIT, and set on the DECODE edge of an illegal instruction.
- Exactly one of write/loada/loadb/loadc/loads may be high in any cycle, except that none is high in WAIT and DECODE.

Decomposition:
- Package dp_ctrl_pkg:
  - state encoding (WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG);
  - opcode constants OPC_MOV=110 and OPC_ALU=101;
  - ALUop constants;
  - one-hot VSEL_* constants.
- Sub-module ctrl_decode: combinational IR to {class, Rn, Rd, Rm, sh, op, sximm8, sximm5, illegal}. The FSM and output decode stay in the top module.

Test Plan:
- Reset with load=1, in=16'hFFFF, reset_n=0 -> w=1, err=0, all strobes 0, sximm8=0. After release with no s, the state stays in WAIT.
- MOV R3,#-2 (in=16'hD3FE), load+s on the same edge -> one cycle later WRITE_IMM: write=1, writenum=3, vsel=0001, sximm8=16'hFFFE. w=1 two cycles after s.
- ADD R2,R1,R0,LSL#1 (16'hA148) -> cycle sequence:
  - loada with readnum=1;
  - loadb with readnum=0;
  - loadc with shift=01, ALUop=00, asel=0;
  - write with writenum=2, vsel=0010;
  - w=1 on the 5th cycle.
- CMP R1,R2 (16'hA902) -> EXEC has loads=1 and loadc=0; no write pulse is seen; w=1 after 4 cycles.
- Illegal instruction 16'h0000 -> err=1 and w=1 one cycle after s, with no strobes. A following legal s clears err on its acceptance edge.
- s and load pulsed during GET_B of an ADD -> IR is unchanged, the instruction completes normally, and no second instruction starts. reset_n pulsed low in EXEC -> WAIT immediately, and no write pulse follows.
